// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: access-width encodings, store-buffer FSM state
// and the pending-store entry layout.
package lsu_pkg;

    localparam logic [2:0] MEM_BYTE  = 3'b000;
    localparam logic [2:0] MEM_HALF  = 3'b001;
    localparam logic [2:0] MEM_WORD  = 3'b010;
    localparam logic [2:0] MEM_BYTEU = 3'b100;
    localparam logic [2:0] MEM_HALFU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } sb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  ctrl;
    } sb_entry_t;

    // Only the low address bits matter for alignment; unsigned widths are not legal for stores.
    function automatic logic store_misaligned(input logic [1:0] addr_lo, input logic [2:0] ctrl);
        case (ctrl)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return addr_lo[0];
            MEM_WORD: return addr_lo != 2'b00;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: execute-side store/load requests, flush control and the
// data_memory port. master = execute/memory side, slave = store buffer.
interface store_buffer_if;

    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_ctrl;
    logic        st_misalign;

    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_ctrl;
    logic        ld_stall;
    logic [31:0] ld_data;

    logic        flush_req;
    logic        flush_done;

    logic [31:0] address;
    logic [31:0] datawr;
    logic        dmwr;
    logic [2:0]  dmctrl;
    logic [31:0] datard;

    modport master (
        output st_valid, st_addr, st_data, st_ctrl,
        output ld_valid, ld_addr, ld_ctrl,
        output flush_req, datard,
        input  st_ready, st_misalign, ld_stall, ld_data,
        input  flush_done, address, datawr, dmwr, dmctrl
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_ctrl,
        input  ld_valid, ld_addr, ld_ctrl,
        input  flush_req, datard,
        output st_ready, st_misalign, ld_stall, ld_data,
        output flush_done, address, datawr, dmwr, dmctrl
    );

endinterface

// File: rtl/sb_hazard_check.sv
// Compares a load's word address against every live store-buffer entry; with
// STORE_FWD_EN it also picks the youngest match and qualifies it for forwarding.
module sb_hazard_check
    import lsu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1
) (
    input  logic [DEPTH-1:0][29:0] word_addr,
    input  logic [IDX_W-1:0]       head_idx,
    input  logic [PTR_W-1:0]       count,
    input  logic [29:0]            ld_word,
`ifdef STORE_FWD_EN
    input  sb_entry_t [DEPTH-1:0]  entries,
    input  logic [31:0]            ld_addr,
    input  logic [2:0]             ld_ctrl,
    output logic                   fwd_hit,
    output logic [31:0]            fwd_data,
`endif
    output logic                   hazard
);

    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] match;
    logic [IDX_W-1:0] idx;

    // Live entries are the first count slots starting at the head, wrapping modulo DEPTH.
    always_comb begin
        live  = '0;
        match = '0;
        idx   = head_idx;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_idx + IDX_W'(i);
            if (PTR_W'(i) < count) live[idx] = 1'b1;
        end
        for (int j = 0; j < DEPTH; j++) begin
            match[j] = live[j] && (word_addr[j] == ld_word);
        end
    end

    assign hazard = |match;

`ifdef STORE_FWD_EN
    logic             young_hit;
    logic [IDX_W-1:0] young_idx;
    logic [IDX_W-1:0] scan_idx;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        young_hit = 1'b0;
        young_idx = head_idx;
        scan_idx  = head_idx;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_idx + IDX_W'(i);
            if ((PTR_W'(i) < count) && match[scan_idx]) begin
                young_hit = 1'b1;
                young_idx = scan_idx;
            end
        end
    end

    assign fwd_hit  = young_hit
                   && (entries[young_idx].ctrl == MEM_WORD)
                   && (entries[young_idx].addr == ld_addr)
                   && (ld_ctrl == MEM_WORD);
    assign fwd_data = entries[young_idx].data;
`endif

endmodule

// File: rtl/store_buffer.sv
// Pending-store FIFO between execute and data_memory; loads own the memory port unless
// they hazard. Optional store-to-load forwarding of exact word matches: STORE_FWD_EN.
//
// state  | meaning
// IDLE   | buffer empty, no flush in progress
// ACTIVE | one or more stores pending
// FLUSH  | draining everything; stores refused, loads stalled
module store_buffer
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    store_buffer_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    sb_entry_t [DEPTH-1:0]  entries;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       count;
    logic [PTR_W-1:0]       count_nxt;
    sb_state_t              state;
    logic                   misalign_q;
    logic                   flush_done_q;

    logic                   full;
    logic                   empty;
    logic                   st_open;
    logic                   accept;
    logic                   bad;
    logic                   push;
    logic                   pop;
    logic                   hazard;
    logic                   fwd;
    logic                   stall;
    logic                   load_port;
    logic [DEPTH-1:0][29:0] word_addr;
    sb_entry_t              head;

    assign full      = (count == PTR_W'(DEPTH));
    assign empty     = (count == '0);
    assign st_open   = !full && (state != FLUSH);
    assign accept    = bus.st_valid && st_open;
    assign bad       = store_misaligned(bus.st_addr[1:0], bus.st_ctrl);
    assign push      = accept && !bad;
    assign head      = entries[rd_ptr[IDX_W-1:0]];
    assign count_nxt = count + PTR_W'(push) - PTR_W'(pop);

    always_comb begin
        word_addr = '0;
        for (int i = 0; i < DEPTH; i++) word_addr[i] = entries[i].addr[31:2];
    end

`ifdef STORE_FWD_EN
    logic        fwd_hit;
    logic [31:0] fwd_data;

    sb_hazard_check #(.DEPTH(DEPTH)) u_hazard (
        .word_addr (word_addr),
        .head_idx  (rd_ptr[IDX_W-1:0]),
        .count     (count),
        .ld_word   (bus.ld_addr[31:2]),
        .entries   (entries),
        .ld_addr   (bus.ld_addr),
        .ld_ctrl   (bus.ld_ctrl),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .hazard    (hazard)
    );

    assign fwd = bus.ld_valid && fwd_hit && (state != FLUSH);
`else
    sb_hazard_check #(.DEPTH(DEPTH)) u_hazard (
        .word_addr (word_addr),
        .head_idx  (rd_ptr[IDX_W-1:0]),
        .count     (count),
        .ld_word   (bus.ld_addr[31:2]),
        .hazard    (hazard)
    );

    assign fwd = 1'b0;
`endif

    // A forwarded load never touches memory, so the head may drain alongside it.
    assign stall     = bus.ld_valid && ((state == FLUSH) || (hazard && !fwd));
    assign load_port = bus.ld_valid && !stall && !fwd;
    assign pop       = !empty && !load_port;

    always_comb begin
        bus.st_ready = 1'b0;
        bus.ld_stall = 1'b0;
        bus.ld_data  = '0;
        bus.address  = '0;
        bus.datawr   = '0;
        bus.dmwr     = 1'b0;
        bus.dmctrl   = '0;
        if (!rst) begin
            bus.st_ready = st_open;
            bus.ld_stall = stall;
            if (load_port) begin
                bus.address = bus.ld_addr;
                bus.dmctrl  = bus.ld_ctrl;
                bus.ld_data = bus.datard;
            end else if (pop) begin
                bus.address = head.addr;
                bus.datawr  = head.data;
                bus.dmctrl  = head.ctrl;
                bus.dmwr    = 1'b1;
            end
`ifdef STORE_FWD_EN
            if (fwd) bus.ld_data = fwd_data;
`endif
        end
    end

    assign bus.st_misalign = misalign_q;
    assign bus.flush_done  = flush_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            entries <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr[IDX_W-1:0]] <= '{addr: bus.st_addr, data: bus.st_data, ctrl: bus.st_ctrl};
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            misalign_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            misalign_q   <= accept && bad;
            flush_done_q <= 1'b0;
            case (state)
                FLUSH: begin
                    if (empty) begin
                        state        <= IDLE;
                        flush_done_q <= 1'b1;
                    end
                end
                default: begin
                    if (bus.flush_req)          state <= FLUSH;
                    else if (count_nxt == '0)   state <= IDLE;
                    else                        state <= ACTIVE;
                end
            endcase
        end
    end

endmodule
